dmem_access_ctrl: RTL

DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

---
 rtl/dmem_access_ctrl_if.sv | 29 ++
 rtl/dmem_access_ctrl.sv | 104 ++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl_if.sv
// dmem_access_ctrl_if: EX/MEM access signals and data-memory bus for the load/store controller
// master : controller view  -- takes EX/MEM request + memory response, drives memory request,
//          pipeline stall and load results
// slave  : environment view -- pipeline and memory model driving the opposite directions
interface dmem_access_ctrl_if;
   logic        MemRead_EXMEM;
   logic        MemWrite_EXMEM;
   logic [31:0] ALUOut_EXMEM;
   logic [31:0] MEM_data_EXMEM;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        stall;
   logic [31:0] load_data;
   logic        load_valid;
   logic        align_err;
   logic        bus_err;
   modport master (
      input  MemRead_EXMEM, MemWrite_EXMEM, ALUOut_EXMEM, MEM_data_EXMEM, mem_ready, mem_rdata,
      output mem_req, mem_we, mem_addr, mem_wdata, stall, load_data, load_valid, align_err, bus_err
   );
   modport slave (
      output MemRead_EXMEM, MemWrite_EXMEM, ALUOut_EXMEM, MEM_data_EXMEM, mem_ready, mem_rdata,
      input  mem_req, mem_we, mem_addr, mem_wdata, stall, load_data, load_valid, align_err, bus_err
   );
endinterface

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: MEM-stage data-memory access controller with pipeline stall
// Ports:
//   CLK  - single clock, rising edge
//   RST  - synchronous active-high reset
//   bus  - dmem_access_ctrl_if.master: EX/MEM load/store request in, mem_req/mem_we/mem_addr/
//          mem_wdata out with mem_ready/mem_rdata back, stall, load_data/load_valid, align_err, bus_err
// Optional feature: define DMEM_TIMEOUT_EN to abort a BUSY access after TIMEOUT_CYCLES cycles
// without mem_ready (bus_err pulse); when undefined BUSY waits indefinitely and bus_err is 0.
module dmem_access_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input logic CLK,
   input logic RST,
   dmem_access_ctrl_if.master bus
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d, ldata_q, ldata_d;
   logic        we_q, we_d, lv_q, lv_d, ae_q, ae_d, be_q, be_d;
   logic        pending, timeout;
   assign pending = bus.MemRead_EXMEM | bus.MemWrite_EXMEM;
`ifdef DMEM_TIMEOUT_EN
   logic [7:0] cnt_q, cnt_d;
   assign timeout = (cnt_q == 8'(TIMEOUT_CYCLES - 1));
   always_ff @(posedge CLK) cnt_q <= RST ? 8'd0 : cnt_d;
`else
   assign timeout = 1'b0;
`endif
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         ldata_q <= '0;
         we_q    <= 1'b0;
         lv_q    <= 1'b0;
         ae_q    <= 1'b0;
         be_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         ldata_q <= ldata_d;
         we_q    <= we_d;
         lv_q    <= lv_d;
         ae_q    <= ae_d;
         be_q    <= be_d;
      end
   end
   // Pulse flags are registered on the transition into DONE, so they last exactly the one DONE cycle.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      ldata_d = ldata_q;
      we_d    = we_q;
      lv_d    = 1'b0;
      ae_d    = 1'b0;
      be_d    = 1'b0;
`ifdef DMEM_TIMEOUT_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (pending && bus.ALUOut_EXMEM[1:0] == 2'b00) begin
               state_d = BUSY;
               addr_d  = bus.ALUOut_EXMEM;
               wdata_d = bus.MEM_data_EXMEM;
               we_d    = bus.MemWrite_EXMEM;
`ifdef DMEM_TIMEOUT_EN
               cnt_d   = 8'd0;
`endif
            end else if (pending) begin
               state_d = DONE;
               ae_d    = 1'b1;
            end
         end
         BUSY: begin
            if (bus.mem_ready) begin
               state_d = DONE;
               lv_d    = ~we_q;
               ldata_d = we_q ? ldata_q : bus.mem_rdata;
            end else if (timeout) begin
               state_d = DONE;
               be_d    = 1'b1;
            end
`ifdef DMEM_TIMEOUT_EN
            else cnt_d = cnt_q + 8'd1;
`endif
         end
         default: state_d = IDLE;
      endcase
   end
   assign bus.mem_req    = (state_q == BUSY);
   assign bus.mem_we     = (state_q == BUSY) & we_q;
   assign bus.mem_addr   = addr_q;
   assign bus.mem_wdata  = wdata_q;
   // DONE releases the pipeline for one cycle so the EX/MEM instruction retires without reissue.
   assign bus.stall      = (state_q == IDLE && pending) || state_q == BUSY;
   assign bus.load_data  = ldata_q;
   assign bus.load_valid = lv_q;
   assign bus.align_err  = ae_q;
   assign bus.bus_err    = be_q;
endmodule
